// File: rtl/button_event_arbiter.sv
// button_event_arbiter
// Latches one-cycle press pulses from N button front-ends as pending
// requests and grants them round-robin onto one valid/ready event channel.
// After each accepted event the block inserts a GAP-cycle hold-off.
// Optional feature macro: BTN_ARB_DROPCNT_EN adds a saturating 8-bit
// count of lost presses on the drop_cnt port.
module button_event_arbiter #(
   parameter int N   = 4,
   parameter int IDW = 2,
   parameter int GAP = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   btn_pulse,
   input  logic           evt_ready,
   input  logic           ovf_clr,
   output logic           evt_valid,
   output logic [IDW-1:0] evt_id,
   output logic           busy,
   output logic           overflow
`ifdef BTN_ARB_DROPCNT_EN
   ,
   output logic [7:0]     drop_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_OFFER   = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_t;

   localparam logic       HAS_GAP  = (GAP > 0);
   localparam logic [7:0] GAP_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

   state_t         state_r;
   logic [N-1:0]   pend_r;
   logic [IDW-1:0] rr_ptr_r;
   logic [7:0]     gap_cnt_r;
   logic           evt_valid_r;
   logic [IDW-1:0] evt_id_r;
   logic           busy_r;
   logic           overflow_r;

   logic           accept_s;
   logic [N-1:0]   acc_mask_s;
   logic [N-1:0]   drop_mask_s;
   logic [N-1:0]   pend_nxt_s;
   logic           drop_any_s;
   logic           grant_found_s;
   logic [IDW-1:0] grant_id_s;
   logic [IDW:0]   cand_s;
   logic [IDW-1:0] rr_nxt_s;

   // evt_valid_r is only ever high in OFFER, so it doubles as the state qualifier
   assign accept_s    = evt_valid_r & evt_ready;
   assign drop_mask_s = btn_pulse & pend_r & ~acc_mask_s;
   // A pulse on the index being accepted re-arms it (set wins over clear)
   assign pend_nxt_s  = (pend_r & ~acc_mask_s) | btn_pulse;
   assign drop_any_s  = |drop_mask_s;

   // One-hot mask of the request being retired this cycle
   always_comb begin
      acc_mask_s = {N{1'b0}};
      if (accept_s) begin
         acc_mask_s[evt_id_r] = 1'b1;
      end else begin
         acc_mask_s = {N{1'b0}};
      end
   end

   // Round-robin search upward from rr_ptr with wrap; lowest distance wins,
   // so iterate from the farthest candidate and let nearer ones overwrite
   always_comb begin
      grant_found_s = 1'b0;
      grant_id_s    = {IDW{1'b0}};
      cand_s        = {(IDW+1){1'b0}};
      for (int k = N - 1; k >= 0; k--) begin
         cand_s = {1'b0, rr_ptr_r} + (IDW+1)'(k);
         if (cand_s >= (IDW+1)'(N)) begin
            cand_s = cand_s - (IDW+1)'(N);
         end else begin
            cand_s = cand_s;
         end
         if (pend_r[cand_s[IDW-1:0]]) begin
            grant_found_s = 1'b1;
            grant_id_s    = cand_s[IDW-1:0];
         end else begin
            grant_found_s = grant_found_s;
            grant_id_s    = grant_id_s;
         end
      end
   end

   // Pointer moves to the index just after the accepted grant, modulo N
   always_comb begin
      if (evt_id_r == IDW'(N - 1)) begin
         rr_nxt_s = {IDW{1'b0}};
      end else begin
         rr_nxt_s = evt_id_r + IDW'(1);
      end
   end

`ifdef BTN_ARB_DROPCNT_EN
   logic [7:0] drop_cnt_r;
   logic [7:0] drop_base_s;
   logic [8:0] drop_sum_s;
   logic [7:0] drop_cnt_nxt_s;

   function automatic logic [3:0] popcount(input logic [N-1:0] v);
      logic [3:0] c;
      c = 4'd0;
      for (int i = 0; i < N; i++) begin
         c = c + {3'd0, v[i]};
      end
      return c;
   endfunction

   // Clear and drops in the same cycle: the clear zeroes the base, drops still add
   always_comb begin
      if (ovf_clr) begin
         drop_base_s = 8'd0;
      end else begin
         drop_base_s = drop_cnt_r;
      end
      drop_sum_s = {1'b0, drop_base_s} + {5'd0, popcount(drop_mask_s)};
      if (drop_sum_s[8]) begin
         drop_cnt_nxt_s = 8'd255;
      end else begin
         drop_cnt_nxt_s = drop_sum_s[7:0];
      end
   end

   // Saturating lost-press counter
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt_r <= 8'd0;
      end else begin
         drop_cnt_r <= drop_cnt_nxt_s;
      end
   end

   assign drop_cnt = drop_cnt_r;
`endif

   // Arbiter FSM with pending set, sticky overflow and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         pend_r      <= {N{1'b0}};
         rr_ptr_r    <= {IDW{1'b0}};
         gap_cnt_r   <= 8'd0;
         evt_valid_r <= 1'b0;
         evt_id_r    <= {IDW{1'b0}};
         busy_r      <= 1'b0;
         overflow_r  <= 1'b0;
      end else begin
         pend_r <= pend_nxt_s;
         if (drop_any_s) begin
            overflow_r <= 1'b1;
         end else if (ovf_clr) begin
            overflow_r <= 1'b0;
         end else begin
            overflow_r <= overflow_r;
         end
         case (state_r)
            ST_IDLE: begin
               if (grant_found_s) begin
                  evt_id_r    <= grant_id_s;
                  evt_valid_r <= 1'b1;
                  busy_r      <= 1'b1;
                  state_r     <= ST_OFFER;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_OFFER: begin
               if (accept_s) begin
                  evt_valid_r <= 1'b0;
                  rr_ptr_r    <= rr_nxt_s;
                  if (HAS_GAP) begin
                     gap_cnt_r <= GAP_LAST;
                     busy_r    <= 1'b1;
                     state_r   <= ST_HOLDOFF;
                  end else begin
                     busy_r  <= 1'b0;
                     state_r <= ST_IDLE;
                  end
               end else begin
                  state_r <= ST_OFFER;
               end
            end
            ST_HOLDOFF: begin
               if (gap_cnt_r == 8'd0) begin
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end else begin
                  gap_cnt_r <= gap_cnt_r - 8'd1;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               evt_valid_r <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign evt_valid = evt_valid_r;
   assign evt_id    = evt_id_r;
   assign busy      = busy_r;
   assign overflow  = overflow_r;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter (N=4, IDW=2, GAP=2).
// Drop-count checks are compiled only with BTN_ARB_DROPCNT_EN.
module tb_button_event_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] btn_pulse;
   logic       evt_ready;
   logic       ovf_clr;
   logic       evt_valid;
   logic [1:0] evt_id;
   logic       busy;
   logic       overflow;
`ifdef BTN_ARB_DROPCNT_EN
   logic [7:0] drop_cnt;
`endif

   int checks;
   int failures;

   button_event_arbiter #(.N(4), .IDW(2), .GAP(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_pulse (btn_pulse),
      .evt_ready (evt_ready),
      .ovf_clr   (ovf_clr),
      .evt_valid (evt_valid),
      .evt_id    (evt_id),
      .busy      (busy),
      .overflow  (overflow)
`ifdef BTN_ARB_DROPCNT_EN
      ,
      .drop_cnt  (drop_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       rst;
      logic [3:0] btn;
      logic       rdy;
      logic       clr;
      logic       v;
      logic [1:0] id;
      logic       b;
      logic       o;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Drive inputs at the falling edge, then sample 1 time unit after the rising edge
   task automatic step(input logic r, input logic [3:0] b, input logic rd, input logic c);
      @(negedge clk);
      rst       = r;
      btn_pulse = b;
      evt_ready = rd;
      ovf_clr   = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      btn_pulse = 4'b0000;
      evt_ready = 1'b0;
      ovf_clr   = 1'b0;

      // rst btn rdy clr | valid id busy ovf
      // Plan 1: single press on btn 2
      vecs.push_back('{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0});
      // Plan 2: reset, then btns 0,1,3 together -> grants 0,1,3 every 4 cycles
      vecs.push_back('{1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 4'b1011, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0});
      // Plan 4: pulse on btn 0 in its own accept cycle re-arms it, no overflow
      vecs.push_back('{1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0});

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rst, vecs[i].btn, vecs[i].rdy, vecs[i].clr);
         chk($sformatf("vec%0d_valid", i), {31'd0, evt_valid}, {31'd0, vecs[i].v});
         chk($sformatf("vec%0d_id", i), {30'd0, evt_id}, {30'd0, vecs[i].id});
         chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, busy == busy ? vecs[i].b : 1'b0});
         chk($sformatf("vec%0d_ovf", i), {31'd0, overflow}, {31'd0, vecs[i].o});
         if (i == 2) chk("t1_pend_after_pulse", {28'd0, dut.pend_r}, 32'h4);
         if (i == 4) chk("t1_pend_after_accept", {28'd0, dut.pend_r}, 32'h0);
         if (i == 18) chk("t2_rr_after_last", {30'd0, dut.rr_ptr_r}, 32'h0);
         if (i == 23) chk("t4_pend_rearmed", {28'd0, dut.pend_r}, 32'h1);
      end

      // Plan 3: 10-cycle stall on evt_id=1 with a second press on btn 1
      step(1'b1, 4'b0000, 1'b0, 1'b0);
      step(1'b0, 4'b0010, 1'b0, 1'b0);
      step(1'b0, 4'b0000, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         step(1'b0, (k == 3) ? 4'b0010 : 4'b0000, 1'b0, 1'b0);
         chk($sformatf("t3_hold_valid_%0d", k), {31'd0, evt_valid}, 32'h1);
         chk($sformatf("t3_hold_id_%0d", k), {30'd0, evt_id}, 32'h1);
         chk($sformatf("t3_ovf_%0d", k), {31'd0, overflow}, (k >= 3) ? 32'h1 : 32'h0);
      end
`ifdef BTN_ARB_DROPCNT_EN
      chk("t3_drop_cnt", {24'd0, drop_cnt}, 32'h1);
`endif
      step(1'b0, 4'b0000, 1'b1, 1'b0);
      chk("t3_accept_valid", {31'd0, evt_valid}, 32'h0);

      // Plan 5: 300 drops on btn 3 while its event is stalled
      step(1'b1, 4'b0000, 1'b0, 1'b0);
      step(1'b0, 4'b1000, 1'b0, 1'b0);
      step(1'b0, 4'b0000, 1'b0, 1'b0);
      chk("t5_offer_id", {30'd0, evt_id}, 32'h3);
      for (int k = 0; k < 300; k++) begin
         step(1'b0, 4'b1000, 1'b0, 1'b0);
`ifdef BTN_ARB_DROPCNT_EN
         if (k == 253) chk("t5_cnt_254", {24'd0, drop_cnt}, 32'd254);
         if (k == 254) chk("t5_cnt_255", {24'd0, drop_cnt}, 32'd255);
`endif
      end
      chk("t5_ovf_set", {31'd0, overflow}, 32'h1);
`ifdef BTN_ARB_DROPCNT_EN
      chk("t5_cnt_sat", {24'd0, drop_cnt}, 32'd255);
`endif
      step(1'b0, 4'b0000, 1'b0, 1'b1);
      chk("t5_clr_ovf", {31'd0, overflow}, 32'h0);
`ifdef BTN_ARB_DROPCNT_EN
      chk("t5_clr_cnt", {24'd0, drop_cnt}, 32'h0);
`endif
      step(1'b0, 4'b1000, 1'b0, 1'b1);
      chk("t5_clr_vs_drop_ovf", {31'd0, overflow}, 32'h1);
`ifdef BTN_ARB_DROPCNT_EN
      chk("t5_clr_vs_drop_cnt", {24'd0, drop_cnt}, 32'h1);
`endif

      // Plan 6: reset mid-OFFER with pend=1011 discards everything
      step(1'b1, 4'b0000, 1'b0, 1'b0);
      step(1'b0, 4'b1011, 1'b0, 1'b0);
      step(1'b0, 4'b0000, 1'b0, 1'b0);
      chk("t6_offer_valid", {31'd0, evt_valid}, 32'h1);
      chk("t6_pend_before", {28'd0, dut.pend_r}, 32'hb);
      step(1'b1, 4'b0000, 1'b1, 1'b0);
      chk("t6_rst_valid", {31'd0, evt_valid}, 32'h0);
      chk("t6_rst_busy", {31'd0, busy}, 32'h0);
      chk("t6_rst_pend", {28'd0, dut.pend_r}, 32'h0);
      chk("t6_rst_rr", {30'd0, dut.rr_ptr_r}, 32'h0);
      for (int k = 0; k < 8; k++) begin
         step(1'b0, 4'b0000, 1'b1, 1'b0);
         chk($sformatf("t6_quiet_%0d", k), {31'd0, evt_valid}, 32'h0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
